// File: rtl/io_bridge_pkg.sv
// -----------------------------------------------------------------------------
// io_bridge_pkg
//   Shared definitions for the io_bridge block: channel count, word width,
//   channel-index type, display-event record and small channel helpers.
// -----------------------------------------------------------------------------
package io_bridge_pkg;

    localparam int unsigned CH_NUM     = 4;
    localparam int unsigned WORD_W     = 32;
    localparam int unsigned FIFO_DEPTH = 4;

    typedef logic [1:0]        ch_idx_t;
    typedef logic [WORD_W-1:0] word_t;

    typedef struct packed {
        ch_idx_t ch;
        word_t   data;
    } disp_evt_t;

    // Index of the lowest set bit; 0 when no bit is set.
    function automatic ch_idx_t lowest_ch(input logic [CH_NUM-1:0] v);
        ch_idx_t idx;
        logic    found;
        idx   = '0;
        found = 1'b0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (v[i] && !found) begin
                idx   = ch_idx_t'(i);
                found = 1'b1;
            end
        end
        return idx;
    endfunction

    // True when more than one strobe bit is set.
    function automatic logic multi_hot(input logic [CH_NUM-1:0] v);
        int unsigned n;
        n = 0;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (v[i]) n++;
        end
        return (n > 1);
    endfunction

endpackage

// File: rtl/io_bridge_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
//   Two-flop synchronizer followed by a debouncer. The stable level flips only
//   after the synchronized level has differed from it for DEBOUNCE_CYCLES
//   consecutive cycles; any bounce back restarts the count. A one-cycle pulse
//   is emitted on each accepted 0->1 transition.
//
// Ports
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset (stable level and counter -> 0)
//   btn_i   : raw asynchronous button level
//   rise_o  : one-cycle pulse after a debounced rising edge
// -----------------------------------------------------------------------------
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q;
    logic          stable_q, stable_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rise_q, rise_d;

    always_comb begin
        stable_d = stable_q;
        cnt_d    = cnt_q;
        rise_d   = 1'b0;
        if (sync_q[1] != stable_q) begin
            // The cycle that completes the run flips the level immediately.
            if (cnt_q == CNT_LAST) begin
                stable_d = sync_q[1];
                cnt_d    = '0;
                rise_d   = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end else begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            rise_q   <= 1'b0;
        end else begin
            sync_q   <= {sync_q[0], btn_i};
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            rise_q   <= rise_d;
        end
    end

    assign rise_o = rise_q;

endmodule

// File: rtl/io_bridge.sv
// -----------------------------------------------------------------------------
// io_bridge
//   Bridges board switches/button to a 4-channel processor input port and
//   turns processor output writes into a valid/ready display stream.
//
//   Input path : debounced button press loads sw into dev_in word in_sel and
//                pulses enter_in[in_sel] for one cycle.
//   Output path: each enter_out write queues {ch, dev_out word}; several
//                strobes in one cycle keep only the lowest channel and set
//                the sticky overflow flag.
//
//   Build option IO_BRIDGE_FIFO_EN:
//     defined   - 4-entry display FIFO, events arriving when full (and not
//                 dequeuing) are dropped and set overflow.
//     undefined - single holding register, a new event while the held one
//                 is stalled overwrites it and sets overflow.
//
// Ports
//   clk        : clock, rising edge
//   rst        : synchronous active-high reset
//   sw         : 32-bit switch word
//   btn        : raw enter button
//   in_sel     : target channel for the next capture
//   dev_in     : 4 x 32-bit processor input words (word i at [32i+31:32i])
//   enter_in   : per-channel one-cycle new-input strobe
//   dev_out    : 4 x 32-bit processor output words
//   enter_out  : per-channel processor write strobe
//   disp_data  : display event data
//   disp_ch    : display event channel
//   disp_valid : display event valid
//   disp_ready : display sink ready
//   overflow   : sticky dropped-event flag, cleared only by rst
// -----------------------------------------------------------------------------
module io_bridge
    import io_bridge_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 50000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [31:0]  sw,
    input  logic         btn,
    input  logic [1:0]   in_sel,
    output logic [127:0] dev_in,
    output logic [3:0]   enter_in,
    input  logic [127:0] dev_out,
    input  logic [3:0]   enter_out,
    output logic [31:0]  disp_data,
    output logic [1:0]   disp_ch,
    output logic         disp_valid,
    input  logic         disp_ready,
    output logic         overflow
);

    // ------------------------------------------------------------------
    // Input path
    // ------------------------------------------------------------------
    logic rise;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i  (clk),
        .rst_i  (rst),
        .btn_i  (btn),
        .rise_o (rise)
    );

    logic [127:0] dev_in_q, dev_in_d;
    logic [3:0]   enter_in_q, enter_in_d;

    always_comb begin
        dev_in_d   = dev_in_q;
        enter_in_d = '0;
        if (rise) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                if (ch_idx_t'(i) == in_sel) begin
                    dev_in_d[i*WORD_W +: WORD_W] = sw;
                    enter_in_d[i]                = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dev_in_q   <= '0;
            enter_in_q <= '0;
        end else begin
            dev_in_q   <= dev_in_d;
            enter_in_q <= enter_in_d;
        end
    end

    assign dev_in   = dev_in_q;
    assign enter_in = enter_in_q;

    // ------------------------------------------------------------------
    // Output path: event formation
    // ------------------------------------------------------------------
    logic      push;
    logic      multi;
    disp_evt_t push_evt;
    ch_idx_t   push_ch;

    always_comb begin
        push_ch       = lowest_ch(enter_out);
        push_evt      = '0;
        push_evt.ch   = push_ch;
        for (int unsigned i = 0; i < CH_NUM; i++) begin
            if (ch_idx_t'(i) == push_ch) begin
                push_evt.data = dev_out[i*WORD_W +: WORD_W];
            end
        end
        push  = |enter_out;
        multi = multi_hot(enter_out);
    end

    logic      valid;
    logic      lost;
    disp_evt_t head;

`ifdef IO_BRIDGE_FIFO_EN
    // ------------------------------------------------------------------
    // Display storage: 4-entry FIFO
    // ------------------------------------------------------------------
    disp_evt_t mem_q [FIFO_DEPTH];
    disp_evt_t mem_d [FIFO_DEPTH];
    logic [1:0] rd_q, rd_d;
    logic [1:0] wr_q, wr_d;
    logic [2:0] cnt_q, cnt_d;
    logic       deq;
    logic       full;
    logic       accept;

    always_comb begin
        valid  = (cnt_q != '0);
        deq    = valid & disp_ready;
        full   = (cnt_q == 3'(FIFO_DEPTH));
        // When full, a same-cycle dequeue frees the slot the write lands in.
        accept = push & (~full | deq);
        lost   = push & full & ~deq;

        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (accept) begin
            mem_d[wr_q] = push_evt;
            wr_d        = wr_q + 2'd1;
        end
        if (deq) begin
            rd_d = rd_q + 2'd1;
        end
        case ({accept, deq})
            2'b10:   cnt_d = cnt_q + 3'd1;
            2'b01:   cnt_d = cnt_q - 3'd1;
            default: cnt_d = cnt_q;
        endcase

        head = valid ? mem_q[rd_q] : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_q <= '{default: '0};
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end
`else
    // ------------------------------------------------------------------
    // Display storage: single holding register
    // ------------------------------------------------------------------
    disp_evt_t hold_q, hold_d;
    logic      hvalid_q, hvalid_d;

    always_comb begin
        valid    = hvalid_q;
        hold_d   = hold_q;
        hvalid_d = hvalid_q;
        lost     = 1'b0;
        if (push) begin
            hold_d   = push_evt;
            hvalid_d = 1'b1;
            lost     = hvalid_q & ~disp_ready;
        end else if (hvalid_q && disp_ready) begin
            hvalid_d = 1'b0;
        end
        head = valid ? hold_q : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q   <= '0;
            hvalid_q <= 1'b0;
        end else begin
            hold_q   <= hold_d;
            hvalid_q <= hvalid_d;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Sticky overflow
    // ------------------------------------------------------------------
    logic overflow_q, overflow_d;

    always_comb begin
        overflow_d = overflow_q | multi | lost;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign disp_valid = valid;
    assign disp_data  = head.data;
    assign disp_ch    = head.ch;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_io_bridge.sv
// -----------------------------------------------------------------------------
// tb_io_bridge
//   Scoreboard bench for io_bridge with DEBOUNCE_CYCLES = 4. Stimulus pushes
//   expected captures; a cycle model tracks the expected display queue and
//   overflow; a monitor on the falling edge compares the DUT against both.
//   Honours IO_BRIDGE_FIFO_EN for the display storage depth.
// -----------------------------------------------------------------------------
module tb_io_bridge;

    localparam int N = 4;
`ifdef IO_BRIDGE_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic         clk;
    logic         rst;
    logic [31:0]  sw;
    logic         btn;
    logic [1:0]   in_sel;
    logic [127:0] dev_in;
    logic [3:0]   enter_in;
    logic [127:0] dev_out;
    logic [3:0]   enter_out;
    logic [31:0]  disp_data;
    logic [1:0]   disp_ch;
    logic         disp_valid;
    logic         disp_ready;
    logic         overflow;

    io_bridge #(.DEBOUNCE_CYCLES(N)) dut (
        .clk        (clk),
        .rst        (rst),
        .sw         (sw),
        .btn        (btn),
        .in_sel     (in_sel),
        .dev_in     (dev_in),
        .enter_in   (enter_in),
        .dev_out    (dev_out),
        .enter_out  (enter_out),
        .disp_data  (disp_data),
        .disp_ch    (disp_ch),
        .disp_valid (disp_valid),
        .disp_ready (disp_ready),
        .overflow   (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int ch; logic [31:0] data; } ev_t;
    typedef struct { int sel; logic [31:0] val; } cap_t;

    ev_t         dq[$];
    cap_t        cq[$];
    logic [31:0] model_word[4];
    bit          exp_ovf;
    bit          in_rst;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model of the display stream: a bounded queue of events.
    task automatic model_step();
        ev_t ev;
        int  n;
        int  lo;
        if (rst) begin
            dq.delete();
            cq.delete();
            for (int i = 0; i < 4; i++) model_word[i] = '0;
            exp_ovf = 0;
            in_rst  = 1;
        end else begin
            in_rst = 0;
            if (disp_ready && dq.size() > 0) void'(dq.pop_front());
            if (enter_out != 4'b0) begin
                n  = 0;
                lo = -1;
                for (int i = 0; i < 4; i++) begin
                    if (enter_out[i]) begin
                        n++;
                        if (lo < 0) lo = i;
                    end
                end
                ev.ch   = lo;
                ev.data = dev_out[lo*32 +: 32];
                if (n > 1) exp_ovf = 1;
                if (dq.size() < DEPTH) begin
                    dq.push_back(ev);
                end else begin
                    exp_ovf = 1;
`ifndef IO_BRIDGE_FIFO_EN
                    dq[0] = ev;
`endif
                end
            end
        end
    endtask

    always @(posedge clk) model_step();

    task automatic monitor_step();
        cap_t c;
        if (enter_in != 4'b0) begin
            if (cq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_capture: got enter_in=%b expected none at %0t", enter_in, $time);
            end else begin
                c = cq.pop_front();
                check("enter_in", 128'(enter_in), 128'(4'b0001 << c.sel));
                model_word[c.sel] = c.val;
            end
        end
        check("dev_in", dev_in, {model_word[3], model_word[2], model_word[1], model_word[0]});
        check("disp_valid", 128'(disp_valid), 128'(dq.size() != 0));
        if (dq.size() != 0) begin
            check("disp_ch", 128'(disp_ch), 128'(dq[0].ch));
            check("disp_data", 128'(disp_data), 128'(dq[0].data));
        end
        check("overflow", 128'(overflow), 128'(exp_ovf));
        if (in_rst) begin
            check("rst_enter_in", 128'(enter_in), 128'(0));
            check("rst_disp", 128'({disp_ch, disp_data}), 128'(0));
        end
    endtask

    always @(negedge clk) monitor_step();

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input int sel, input logic [31:0] v, input int hold);
        cap_t c;
        in_sel = 2'(sel);
        sw     = v;
        btn    = 1'b1;
        if (hold >= N) begin
            c.sel = sel;
            c.val = v;
            cq.push_back(c);
        end
        tick(hold);
        btn = 1'b0;
        tick(N + 3);
    endtask

    task automatic input_stim();
        int hold;
        press(2, 32'hDEADBEEF, 10);
        for (int k = 0; k < 5; k++) begin
            btn = 1'b1;
            tick(2);
            btn = 1'b0;
            tick(2);
        end
        tick(N + 3);
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 0) hold = N + 2 + int'($urandom_range(0, 6));
            else hold = int'($urandom_range(1, N - 2));
            press(int'($urandom_range(0, 3)), $urandom, hold);
        end
    endtask

    task automatic output_stim();
        disp_ready = 1'b1;
        dev_out    = {$urandom, $urandom, $urandom, 32'h12345678};
        enter_out  = 4'b0001;
        tick(1);
        enter_out  = 4'b0;
        tick(2);
        disp_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            dev_out   = {$urandom, $urandom, $urandom, $urandom};
            enter_out = 4'(1 << (k % 4));
            tick(1);
        end
        enter_out = 4'b0;
        tick(2);
        disp_ready = 1'b1;
        tick(6);
        disp_ready = 1'b0;
        dev_out    = {$urandom, $urandom, $urandom, $urandom};
        enter_out  = 4'b1010;
        tick(1);
        enter_out  = 4'b0;
        tick(1);
        disp_ready = 1'b1;
        tick(2);
        for (int k = 0; k < 300; k++) begin
            dev_out    = {$urandom, $urandom, $urandom, $urandom};
            enter_out  = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'b0;
            disp_ready = ($urandom_range(0, 3) != 0);
            tick(1);
        end
        enter_out = 4'b0;
    endtask

    task automatic drain(input string name);
        int budget;
        disp_ready = 1'b1;
        enter_out  = 4'b0;
        budget     = 100;
        while ((dq.size() != 0 || cq.size() != 0) && budget > 0) begin
            tick(1);
            budget--;
        end
        check(name, 128'(dq.size() + cq.size()), 128'(0));
    endtask

    initial begin
        cap_t c;
        rst        = 1'b1;
        sw         = '0;
        btn        = 1'b0;
        in_sel     = '0;
        dev_out    = '0;
        enter_out  = '0;
        disp_ready = 1'b0;
        @(posedge clk);
        tick(2);
        rst = 1'b0;
        tick(1);

        fork
            input_stim();
            output_stim();
        join
        drain("drain_main");

        // Reset in the middle of a debounce with an event pending; the button
        // stays held through reset and must then capture exactly once.
        in_sel     = 2'd1;
        sw         = $urandom;
        btn        = 1'b1;
        disp_ready = 1'b0;
        dev_out    = {$urandom, $urandom, $urandom, $urandom};
        enter_out  = 4'b0100;
        tick(1);
        enter_out  = 4'b0;
        tick(2);
        rst = 1'b1;
        tick(2);
        rst   = 1'b0;
        c.sel = 1;
        c.val = sw;
        cq.push_back(c);
        tick(N + 8);
        btn = 1'b0;
        tick(N + 3);
        drain("drain_reset");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
